// File: rtl/add_sub_fu.sv
// Pipelined add/sub functional unit: doubling (prefix) CLA in stage 0, LAT delay stages, CDB request/grant.
// Optional signed-overflow flag per stage and cdb_ovf port when ADDSUB_OVF_FLAG_EN is defined.

// 32-bit carry-lookahead adder with log-depth doubling of group generate/propagate.
module doublingCLA_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] p0;
  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] gn;
  logic [31:0] pn;
  logic [31:0] carry;

  always_comb begin
    p0    = a ^ b;
    g     = a & b;
    // Fold the carry-in into bit 0 so g[i] becomes the carry out of bit i.
    g[0]  = g[0] | (p0[0] & cin);
    p     = p0;
    gn    = g;
    pn    = p;
    for (int d = 1; d < 32; d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = 0; i < 32; i++) begin
        if (i >= d) begin
          gn[i] = g[i] | (p[i] & g[i-d]);
          pn[i] = p[i] & p[i-d];
        end
      end
      g = gn;
      p = pn;
    end
    carry = {g[30:0], cin};
    sum   = p0 ^ carry;
    cout  = g[31];
  end

endmodule

module add_sub_fu #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             cdb_req,
  input  logic             cdb_grant,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [WIDTH-1:0] cdb_data,
  output logic             cdb_cout,
`ifdef ADDSUB_OVF_FLAG_EN
  output logic             cdb_ovf,
`endif
  output logic             busy
);

  // Handshakes: an op moves on an edge where valid & ready are both high.
  // Upstream holds its payload while in_valid & ~in_ready; a result moves to the
  // CDB on the edge where cdb_req & cdb_grant, and cdb_* stay stable until then.

  logic [LAT-1:0]   v;
  logic [TAG_W-1:0] tag_q  [LAT];
  logic [WIDTH-1:0] data_q [LAT];
  logic [LAT-1:0]   cout_q;
`ifdef ADDSUB_OVF_FLAG_EN
  logic [LAT-1:0]   ovf_q;
  logic             ovf_s0;
`endif

  logic             stall;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             cla_cout;

  // Subtraction is A + ~B + 1, with the +1 supplied as the carry-in.
  assign b_eff = in_op ? ~in_b : in_b;

  doublingCLA_32 u_cla (
    .a    (in_a),
    .b    (b_eff),
    .cin  (in_op),
    .sum  (sum),
    .cout (cla_cout)
  );

`ifdef ADDSUB_OVF_FLAG_EN
  assign ovf_s0 = (in_a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != in_a[WIDTH-1]);
`endif

  assign stall    = v[LAT-1] & ~cdb_grant;
  assign in_ready = ~stall & ~flush;
  assign accept   = in_valid & in_ready;
  assign busy     = |v;

  assign cdb_req  = v[LAT-1];
  assign cdb_tag  = tag_q[LAT-1];
  assign cdb_data = data_q[LAT-1];
  assign cdb_cout = cout_q[LAT-1];
`ifdef ADDSUB_OVF_FLAG_EN
  assign cdb_ovf  = ovf_q[LAT-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v      <= '0;
      cout_q <= '0;
`ifdef ADDSUB_OVF_FLAG_EN
      ovf_q  <= '0;
`endif
      for (int i = 0; i < LAT; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (flush) begin
        v <= '0;
      end else if (!stall) begin
        v[0] <= accept;
        for (int i = 1; i < LAT; i++) begin
          v[i] <= v[i-1];
        end
      end
      // Payload only loads behind a valid bit, so an idle output keeps its last value.
      if (!stall && !flush) begin
        if (accept) begin
          tag_q[0]  <= in_tag;
          data_q[0] <= sum;
          cout_q[0] <= cla_cout;
`ifdef ADDSUB_OVF_FLAG_EN
          ovf_q[0]  <= ovf_s0;
`endif
        end
        for (int i = 1; i < LAT; i++) begin
          if (v[i-1]) begin
            tag_q[i]  <= tag_q[i-1];
            data_q[i] <= data_q[i-1];
            cout_q[i] <= cout_q[i-1];
`ifdef ADDSUB_OVF_FLAG_EN
            ovf_q[i]  <= ovf_q[i-1];
`endif
          end
        end
      end
    end
  end

endmodule
